s_pea_out_collector: RTL and testbench

// Streaming-mode sink at the PEA output edge: consumes pe_res/valid of the output-row PEs and generates the pea_ready

---
 rtl/pea_pkg.sv | 14 +
 rtl/s_out_row_fifo.sv | 52 +++++
 rtl/s_pea_out_collector.sv | 180 ++++++++++++++++++
 tb/tb_s_pea_out_collector.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pea_pkg.sv
// Shared PEA definitions: datapath width, output-collector state encoding and row counter width.
package pea_pkg;

   localparam int unsigned N_BITS        = 32;
   localparam int unsigned OUT_ROW_CNT_W = 16;

   typedef enum logic [1:0] {
      C_IDLE  = 2'd0,
      C_RUN   = 2'd1,
      C_DRAIN = 2'd2,
      C_DONE  = 2'd3
   } collector_state_t;

endpackage

// File: rtl/s_out_row_fifo.sv
// Synchronous row FIFO, DEPTH entries (power of 2), head visible combinationally from storage.
module s_out_row_fifo #(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage needs no reset; occupancy is tracked by count_q.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/s_pea_out_collector.sv
// Streaming sink at the PEA output edge: captures rows, buffers them, serializes enabled lanes.
// Optional stall counter port stall_cnt_o when S_COLLECT_PERF_EN is defined.
module s_pea_out_collector #(
   parameter int unsigned N_LANES = 4,
   parameter int unsigned N_BITS  = pea_pkg::N_BITS,
   parameter int unsigned DEPTH   = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         start_i,
   input  logic [15:0]                  n_rows_i,
   input  logic [N_LANES-1:0]           lane_en_i,
   input  logic [N_LANES*N_BITS-1:0]    pe_res_i,
   input  logic [N_LANES-1:0]           pe_valid_i,
   output logic                         pea_ready_o,
   output logic [N_BITS-1:0]            out_data_o,
   output logic [$clog2(N_LANES)-1:0]   out_lane_o,
   output logic                         out_last_o,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic                         busy_o,
   output logic                         done_o,
`ifdef S_COLLECT_PERF_EN
   output logic [31:0]                  stall_cnt_o,
`endif
   output logic                         err_o
);

   import pea_pkg::*;

   localparam int unsigned LANE_W = $clog2(N_LANES);
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned ROW_W  = N_LANES * N_BITS;
   localparam int unsigned RC_W   = OUT_ROW_CNT_W;

   collector_state_t   state_q, state_nxt;
   logic [RC_W-1:0]    n_rows_q;
   logic [RC_W-1:0]    cap_cnt_q;
   logic [RC_W-1:0]    out_row_q;
   logic [N_LANES-1:0] lane_en_q;
   logic [LANE_W-1:0]  lane_q;
   logic               pea_ready_q;
   logic               err_q;
   logic               zero_done_q;

   logic [ROW_W-1:0]   head_row;
   logic [CNT_W-1:0]   fifo_cnt;
   logic [CNT_W-1:0]   fifo_cnt_nxt;
   logic               fifo_full;
   logic               fifo_empty;

   logic               start_acc;
   logic               start_ok;
   logic [N_LANES-1:0] en_valid;
   logic               cap_win;
   logic               push;
   logic               skew;
   logic               hs;
   logic               pop;
   logic               lane_last;
   logic               row_last;

   function automatic logic [LANE_W-1:0] low_lane(input logic [N_LANES-1:0] m);
      low_lane = '0;
      for (int i = int'(N_LANES) - 1; i >= 0; i--)
         if (m[i]) low_lane = LANE_W'(i);
   endfunction

   // Next enabled lane above cur, wrapping to the lowest enabled lane.
   function automatic logic [LANE_W-1:0] next_lane(input logic [N_LANES-1:0] m,
                                                   input logic [LANE_W-1:0]  cur);
      next_lane = low_lane(m);
      for (int i = int'(N_LANES) - 1; i >= 0; i--)
         if (m[i] && i > int'(cur)) next_lane = LANE_W'(i);
   endfunction

   assign start_acc    = start_i && (state_q == C_IDLE);
   assign start_ok     = start_acc && (n_rows_i != '0) && (lane_en_i != '0);
   assign en_valid     = pe_valid_i & lane_en_q;
   assign cap_win      = (state_q == C_RUN) && pea_ready_q;
   assign push         = cap_win && (en_valid == lane_en_q) && !fifo_full;
   assign skew         = cap_win && (en_valid != '0) && (en_valid != lane_en_q);
   assign hs           = !fifo_empty && out_ready_i;
   assign lane_last    = (next_lane(lane_en_q, lane_q) <= lane_q);
   assign pop          = hs && lane_last;
   assign row_last     = (out_row_q == n_rows_q - RC_W'(1));
   assign fifo_cnt_nxt = fifo_cnt + CNT_W'(push) - CNT_W'(pop);

   s_out_row_fifo #(
      .WIDTH (ROW_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  (pe_res_i),
      .pop_i   (pop),
      .data_o  (head_row),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= C_IDLE;
      else       state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         C_IDLE:  if (start_ok) state_nxt = C_RUN;
         C_RUN:   if (push && (cap_cnt_q == n_rows_q - RC_W'(1))) state_nxt = C_DRAIN;
         C_DRAIN: if (fifo_empty || (pop && row_last)) state_nxt = C_DONE;
         C_DONE:  state_nxt = C_IDLE;
         default: state_nxt = C_IDLE;
      endcase
   end

   always_comb begin
      busy_o      = (state_q != C_IDLE);
      done_o      = (state_q == C_DONE) || zero_done_q;
      out_valid_o = !fifo_empty;
      out_lane_o  = fifo_empty ? '0 : lane_q;
      out_data_o  = fifo_empty ? '0 : head_row[lane_q*N_BITS +: N_BITS];
      out_last_o  = !fifo_empty && lane_last && row_last;
   end

   // Job bookkeeping, skew flag and registered backpressure.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         n_rows_q    <= '0;
         cap_cnt_q   <= '0;
         out_row_q   <= '0;
         lane_en_q   <= '0;
         lane_q      <= '0;
         err_q       <= 1'b0;
         zero_done_q <= 1'b0;
         pea_ready_q <= 1'b1;
      end else begin
         zero_done_q <= start_acc && !start_ok;
         if (start_acc) begin
            n_rows_q  <= n_rows_i;
            lane_en_q <= lane_en_i;
            cap_cnt_q <= '0;
            out_row_q <= '0;
            lane_q    <= low_lane(lane_en_i);
            err_q     <= 1'b0;
         end else begin
            if (push) cap_cnt_q <= cap_cnt_q + RC_W'(1);
            if (skew) err_q <= 1'b1;
            if (hs) begin
               lane_q <= next_lane(lane_en_q, lane_q);
               if (lane_last) out_row_q <= out_row_q + RC_W'(1);
            end
         end
         // Headroom for one in-flight capture after ready drops.
         pea_ready_q <= (fifo_cnt_nxt <= CNT_W'(DEPTH - 2)) || (state_nxt != C_RUN);
      end
   end

   assign pea_ready_o = pea_ready_q;
   assign err_o       = err_q;

`ifdef S_COLLECT_PERF_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i)
         stall_cnt_q <= '0;
      else if (start_acc)
         stall_cnt_q <= '0;
      else if ((state_q == C_RUN) && !pea_ready_q && (stall_cnt_q != '1))
         stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_s_pea_out_collector.sv
// Directed bench for s_pea_out_collector: expected word stream built from the row vectors and lane masks.
module tb_s_pea_out_collector;

   localparam int unsigned NL = 4;
   localparam int unsigned NB = 32;
   localparam int unsigned DP = 4;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  lane;
      logic        last;
   } word_t;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic             start_i = 1'b0;
   logic [15:0]      n_rows_i = '0;
   logic [NL-1:0]    lane_en_i = '0;
   logic [NL*NB-1:0] pe_res_i = '0;
   logic [NL-1:0]    pe_valid_i = '0;
   logic             out_ready_i = 1'b0;
   logic             pea_ready_o;
   logic [NB-1:0]    out_data_o;
   logic [1:0]       out_lane_o;
   logic             out_last_o;
   logic             out_valid_o;
   logic             busy_o;
   logic             done_o;
   logic             err_o;
`ifdef S_COLLECT_PERF_EN
   logic [31:0]      stall_cnt_o;
`endif

   word_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    done_cnt = 0;
   bit    busy_seen = 1'b0;

   s_pea_out_collector #(.N_LANES(NL), .N_BITS(NB), .DEPTH(DP)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .n_rows_i    (n_rows_i),
      .lane_en_i   (lane_en_i),
      .pe_res_i    (pe_res_i),
      .pe_valid_i  (pe_valid_i),
      .pea_ready_o (pea_ready_o),
      .out_data_o  (out_data_o),
      .out_lane_o  (out_lane_o),
      .out_last_o  (out_last_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
`ifdef S_COLLECT_PERF_EN
      .stall_cnt_o (stall_cnt_o),
`endif
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
   endtask

   // Model: one word per enabled lane, ascending; last flag on the top lane of the final row.
   task automatic expect_row(input logic [31:0] d0, d1, d2, d3,
                             input logic [3:0] en, input bit last_row);
      logic [31:0] d [4];
      int          top = 0;
      word_t       w;
      d = '{d0, d1, d2, d3};
      for (int i = 0; i < 4; i++) if (en[i]) top = i;
      for (int i = 0; i < 4; i++) begin
         if (en[i]) begin
            w.data = d[i];
            w.lane = 2'(i);
            w.last = last_row && (i == top);
            exp_q.push_back(w);
         end
      end
   endtask

   task automatic start_job(input logic [15:0] n, input logic [3:0] en);
      start_i   = 1'b1;
      n_rows_i  = n;
      lane_en_i = en;
      tick();
      start_i   = 1'b0;
   endtask

   // PE side: hold a full-valid row until a cycle with pea_ready_o=1 has passed.
   task automatic push_row(input logic [31:0] d0, d1, d2, d3);
      bit ok = 1'b0;
      pe_res_i   = {d3, d2, d1, d0};
      pe_valid_i = 4'hF;
      for (int k = 0; k < 300 && !ok; k++) begin
         if (pea_ready_o) ok = 1'b1;
         tick();
      end
      pe_valid_i = '0;
      chk("push_accept", 32'(ok), 32'd1);
   endtask

   task automatic wait_done(input int target);
      for (int k = 0; k < 400 && done_cnt < target; k++) tick();
      chk("done_pulses", 32'(done_cnt), 32'(target));
      chk("words_drained", 32'(exp_q.size()), 32'd0);
   endtask

   // Compare process: every accepted word against the model queue.
   always @(negedge clk_i) begin
      word_t w;
      #1;
      if (!rst_i) begin
         if (done_o === 1'b1) done_cnt++;
         if (busy_o === 1'b1) busy_seen = 1'b1;
         if (out_valid_o === 1'b1 && out_ready_i) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", out_data_o, 32'hDEAD_BEEF ^ out_data_o ^ 32'h1);
            end else begin
               w = exp_q.pop_front();
               chk("out_data", out_data_o, w.data);
               chk("out_lane", 32'(out_lane_o), 32'(w.lane));
               chk("out_last", 32'(out_last_o), 32'(w.last));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      rst_i = 1'b0;
      chk("rst_pea_ready", 32'(pea_ready_o), 32'd1);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_out_valid", 32'(out_valid_o), 32'd0);
      chk("rst_out_data", out_data_o, 32'd0);

      // Two full rows, downstream always ready.
      out_ready_i = 1'b1;
      expect_row(32'd1, 32'd2, 32'd3, 32'd4, 4'hF, 1'b0);
      expect_row(32'd5, 32'd6, 32'd7, 32'd8, 4'hF, 1'b1);
      start_job(16'd2, 4'hF);
      push_row(32'd1, 32'd2, 32'd3, 32'd4);
      push_row(32'd5, 32'd6, 32'd7, 32'd8);
      wait_done(1);

      // Sparse mask 0101: only lanes 0 and 2 appear.
      out_ready_i = 1'b0;
      expect_row(32'hA, 32'hB, 32'hC, 32'hD, 4'b0101, 1'b1);
      start_job(16'd1, 4'b0101);
      push_row(32'hA, 32'hB, 32'hC, 32'hD);
      chk("sparse_valid", 32'(out_valid_o), 32'd1);
      chk("sparse_data0", out_data_o, 32'hA);
      chk("sparse_lane0", 32'(out_lane_o), 32'd0);
      chk("sparse_last0", 32'(out_last_o), 32'd0);
      out_ready_i = 1'b1;
      wait_done(2);

      // Backpressure: downstream stalled, six rows offered.
      out_ready_i = 1'b0;
      for (int r = 0; r < 6; r++)
         expect_row(32'h100 + 32'(4*r), 32'h101 + 32'(4*r), 32'h102 + 32'(4*r),
                    32'h103 + 32'(4*r), 4'hF, r == 5);
      start_job(16'd6, 4'hF);
      for (int r = 0; r < 3; r++)
         push_row(32'h100 + 32'(4*r), 32'h101 + 32'(4*r), 32'h102 + 32'(4*r), 32'h103 + 32'(4*r));
      chk("bp_ready_low", 32'(pea_ready_o), 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("bp_ready_held", 32'(pea_ready_o), 32'd0);
         chk("bp_data_stable", out_data_o, 32'h100);
         chk("bp_lane_stable", 32'(out_lane_o), 32'd0);
      end
      out_ready_i = 1'b1;
      for (int r = 3; r < 6; r++)
         push_row(32'h100 + 32'(4*r), 32'h101 + 32'(4*r), 32'h102 + 32'(4*r), 32'h103 + 32'(4*r));
      wait_done(3);

      // Lane skew: partial valid flags error and is not captured.
      start_job(16'd1, 4'hF);
      pe_res_i   = {32'h44, 32'h33, 32'h22, 32'h11};
      pe_valid_i = 4'b1011;
      tick();
      pe_valid_i = '0;
      chk("skew_err", 32'(err_o), 32'd1);
      chk("skew_no_push", 32'(out_valid_o), 32'd0);
      chk("skew_busy", 32'(busy_o), 32'd1);
      expect_row(32'h55, 32'h66, 32'h77, 32'h88, 4'hF, 1'b1);
      push_row(32'h55, 32'h66, 32'h77, 32'h88);
      wait_done(4);
      chk("skew_err_sticky", 32'(err_o), 32'd1);

      // Zero-row start: immediate done, never busy.
      busy_seen = 1'b0;
      start_job(16'd0, 4'hF);
      chk("zero_done", 32'(done_o), 32'd1);
      chk("zero_busy", 32'(busy_o), 32'd0);
      chk("zero_err_cleared", 32'(err_o), 32'd0);
      tick();
      chk("zero_done_pulse", 32'(done_o), 32'd0);
      tick();
      chk("zero_busy_seen", 32'(busy_seen), 32'd0);
      chk("zero_done_cnt", 32'(done_cnt), 32'd5);

      // Reset during drain with two rows buffered.
      out_ready_i = 1'b0;
      start_job(16'd2, 4'hF);
      push_row(32'h901, 32'h902, 32'h903, 32'h904);
      push_row(32'h905, 32'h906, 32'h907, 32'h908);
      chk("drain_busy", 32'(busy_o), 32'd1);
      chk("drain_valid", 32'(out_valid_o), 32'd1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("abort_valid", 32'(out_valid_o), 32'd0);
      chk("abort_ready", 32'(pea_ready_o), 32'd1);
      chk("abort_busy", 32'(busy_o), 32'd0);
      chk("abort_done", 32'(done_o), 32'd0);
      repeat (5) tick();
      chk("abort_no_done", 32'(done_cnt), 32'd5);

      // Recovery: single top-lane job.
      out_ready_i = 1'b1;
      expect_row(32'hC0, 32'hC1, 32'hC2, 32'hC3, 4'b1000, 1'b1);
      start_job(16'd1, 4'b1000);
      push_row(32'hC0, 32'hC1, 32'hC2, 32'hC3);
      wait_done(6);

      repeat (2) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
